mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access for them. Issues word-aligned requests with byte enables over a req/ack handshake to data memory, stalls the front of the pipeline while the access is outstanding, and sign-extends load data. Its registered outputs feed the MEM/WB register inputs directly.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.
- Clock  in  1  rising-edge clock.
- ResetN  in  1  synchronous, active-low reset.
- ReadData2In  in  32  store data from EX/MEM.
- ALUResultIn  in  32  byte address for memory ops, or pass-through result.
- WriteRegisterIn  in  32  destination register, passed through.
- MemWriteIn  in  2  00 none, 01 sw, 10 sh, 11 sb.
- MemReadIn  in  2  00 none, 01 lw, 10 lh (sign-extend), 11 lb (sign-extend).
- RegWriteIn, MemToRegIn  in  1 each  control, passed through.
- DMemAck  in  1  memory completes the current request; may be high in the first request cycle.
- DMemRData  in  32  read word; valid when DMemAck=1.
- DMemReq  out  1  request valid.
- DMemWe  out  1  1 = write, 0 = read.
- DMemAddr  out  32  {ALUResultIn[31:2], 2'b00}.
- DMemByteEn  out  4  lane enables; lane 0 = bits [7:0] (little-endian).
- DMemWData  out  32  lane-replicated store data.
- Stall  out  1  combinational; holds EX/MEM and all earlier stages.
- ReadDataOut, ALUResultOut, WriteRegisterOut  out  32 each  to MEM/WB.
- RegWriteOut, MemToRegOut  out  1 each  to MEM/WB.
- AlignFault  out  1  one-cycle registered pulse on a misaligned or illegal op.

## Operation
- FSM states: IDLE, BUSY.
- In IDLE with MemReadIn≠0 or MemWriteIn≠0, the op is legal and aligned, so: Stall=1 and the next state is BUSY. At that edge, latch Req=1, We, Addr, ByteEn and WData.
- In IDLE with no memory op: Stall=0. At the edge, outputs load ALUResultIn, WriteRegisterIn, RegWriteIn, MemToRegIn. ReadDataOut becomes 0.
- In BUSY: DMemReq=1 and all DMem* outputs hold stable. Stall = !DMemAck.
- When DMemAck=1 in BUSY: at that edge, the next state is IDLE, DMemReq drops to 0, and MEM/WB outputs load.
  - Loads: ReadDataOut = extracted, extended data.
  - Stores: ReadDataOut = 0.
- While Stall=1, MEM/WB outputs load a bubble: RegWriteOut=0, MemToRegOut=0. The other outputs are don't-care.
- Alignment:
  - lw and sw need addr[1:0]=00.
  - lh and sh need addr[0]=0.
  - Byte ops are always aligned.
- Illegal op: MemReadIn and MemWriteIn both nonzero.
- Misaligned or illegal op: no request is issued and Stall=0. At the edge, AlignFault=1 and a bubble is loaded (RegWriteOut=0). The instruction retires.
- Byte enables:
  - Word: 1111.
  - Half: 0011 at offset 0, 1100 at offset 2.
  - Byte: 0001 << addr[1:0].
- Store data:
  - sw: ReadData2In as-is.
  - sh: {2{ReadData2In[15:0]}}.
  - sb: {4{ReadData2In[7:0]}}.
- Load extraction:
  - lh: bits [16*addr[1]+15 : 16*addr[1]], sign-extended.
  - lb: byte addr[1:0], sign-extended.
- DMemAck in IDLE is ignored.

## Timing
- Reset (ResetN=0 at an edge): state IDLE, and every registered output is 0. Stall is combinational, so it may be high during reset.
- Reset mid-access: DMemReq drops at that edge and the pending op is abandoned. After reset, EX/MEM is reloaded by its own reset/flush.
- Non-memory op: 1 cycle and no stall.
- Memory op: minimum 2 cycles (Stall high 1 cycle) when DMemAck is high in the first BUSY cycle. In general, 1 + N cycles, where N = BUSY cycles until DMemAck.
- Back-to-back memory ops: the second op enters IDLE on the edge where the first completes. Its request issues one edge later, so there is one idle memory cycle between requests.
- AlignFault is high for exactly one cycle per faulting op.

## Test plan
- ALU op: ALUResultIn=0x1234, WriteRegisterIn=5, RegWriteIn=1 -> next cycle: ALUResultOut=0x1234, WriteRegisterOut=5, RegWriteOut=1, Stall never high, DMemReq=0.
- lw at 0x100, DMemAck high in the first BUSY cycle, DMemRData=0xDEADBEEF -> DMemAddr=0x100, ByteEn=1111, Stall high 1 cycle, then ReadDataOut=0xDEADBEEF and MemToRegOut=1.
- lb at 0x103 with DMemRData=0x80FFFFFF -> ByteEn=1000, ReadDataOut=0xFFFFFF80. lh at 0x102 with DMemRData=0x7FFF0000 -> ReadDataOut=0x00007FFF.
- sh at 0x106 with ReadData2In=0xAAAA1234, DMemAck after 3 BUSY cycles -> DMemAddr=0x104, ByteEn=1100, WData=0x12341234, DMemWe=1, Stall high 3 cycles, DMem* stable throughout.
- lw at 0x102 -> no DMemReq, AlignFault=1 for one cycle, RegWriteOut=0, Stall=0. Illegal op (MemRead=01, MemWrite=01) -> same response.
- ResetN low during BUSY -> next edge: DMemReq=0, all outputs 0, state IDLE. A subsequent DMemAck pulse produces no output change.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request bus between the MEM stage and data memory.
// Signals: DMemReq/DMemWe/DMemAddr/DMemByteEn/DMemWData (stage -> memory),
//          DMemAck/DMemRData (memory -> stage).
interface mem_access_stage_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              DMemReq;
  logic              DMemWe;
  logic [DATA_W-1:0] DMemAddr;
  logic [BE_W-1:0]   DMemByteEn;
  logic [DATA_W-1:0] DMemWData;
  logic              DMemAck;
  logic [DATA_W-1:0] DMemRData;

  // Stage side: issues requests, receives completion.
  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
    input  DMemAck, DMemRData
  );

  // Memory side.
  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
    output DMemAck, DMemRData
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-stage controller: takes EX/MEM outputs, performs the data-memory
// access over a req/ack handshake, stalls earlier stages while it is
// outstanding, and sign-extends load data into the MEM/WB register inputs.
// Ports:
//   Clock, ResetN         rising-edge clock, synchronous active-low reset
//   EX/MEM inputs         ReadData2In, ALUResultIn, WriteRegisterIn,
//                         MemWriteIn, MemReadIn, RegWriteIn, MemToRegIn
//   bus (master)          data-memory request/ack interface
//   Stall                 combinational hold for EX/MEM and earlier stages
//   MEM/WB outputs        ReadDataOut, ALUResultOut, WriteRegisterOut,
//                         RegWriteOut, MemToRegOut (registered)
//   AlignFault            registered one-cycle pulse on misaligned/illegal op
module mem_access_stage (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic [31:0]               ReadData2In,
  input  logic [31:0]               ALUResultIn,
  input  logic [31:0]               WriteRegisterIn,
  input  logic [1:0]                MemWriteIn,
  input  logic [1:0]                MemReadIn,
  input  logic                      RegWriteIn,
  input  logic                      MemToRegIn,
  mem_access_stage_if.master        bus,
  output logic                      Stall,
  output logic [31:0]               ReadDataOut,
  output logic [31:0]               ALUResultOut,
  output logic [31:0]               WriteRegisterOut,
  output logic                      RegWriteOut,
  output logic                      MemToRegOut,
  output logic                      AlignFault
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdout_d, alu_d, wreg_d;
  logic              regw_d, m2r_d, fault_d;

  logic              is_mem, is_load, is_store, illegal, misaligned, fault;
  logic [1:0]        size, offs;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c, load_c;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;

  // Op decode: size code 01 word, 10 half, 11 byte, shared by loads and stores.
  assign is_load    = |MemReadIn;
  assign is_store   = |MemWriteIn;
  assign is_mem     = is_load || is_store;
  assign illegal    = is_load && is_store;
  assign size       = is_load ? MemReadIn : MemWriteIn;
  assign offs       = ALUResultIn[1:0];
  assign misaligned = ((size == 2'b01) && (offs != 2'b00)) ||
                      ((size == 2'b10) && offs[0]);
  assign fault      = is_mem && (illegal || misaligned);

  // Lane enables and lane-replicated store data.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ReadData2In;
    case (size)
      2'b10: begin
        be_c    = offs[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ReadData2In[15:0]}};
      end
      2'b11: begin
        be_c    = BE_W'(4'b0001 << offs);
        wdata_c = {4{ReadData2In[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction with sign extension.
  assign half_sel = offs[1] ? bus.DMemRData[31:16] : bus.DMemRData[15:0];
  always_comb begin
    case (offs)
      2'b00:   byte_sel = bus.DMemRData[7:0];
      2'b01:   byte_sel = bus.DMemRData[15:8];
      2'b10:   byte_sel = bus.DMemRData[23:16];
      default: byte_sel = bus.DMemRData[31:24];
    endcase
  end

  always_comb begin
    case (MemReadIn)
      2'b10:   load_c = {{16{half_sel[15]}}, half_sel};
      2'b11:   load_c = {{24{byte_sel[7]}}, byte_sel};
      default: load_c = bus.DMemRData;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q          <= IDLE;
      req_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      be_q             <= '0;
      wdata_q          <= '0;
      ReadDataOut      <= '0;
      ALUResultOut     <= '0;
      WriteRegisterOut <= '0;
      RegWriteOut      <= 1'b0;
      MemToRegOut      <= 1'b0;
      AlignFault       <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      be_q             <= be_d;
      wdata_q          <= wdata_d;
      ReadDataOut      <= rdout_d;
      ALUResultOut     <= alu_d;
      WriteRegisterOut <= wreg_d;
      RegWriteOut      <= regw_d;
      MemToRegOut      <= m2r_d;
      AlignFault       <= fault_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mem && !fault) state_d = BUSY;
      BUSY:    if (bus.DMemAck)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request fields hold while BUSY; MEM/WB defaults to a bubble.
  always_comb begin
    Stall   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdout_d = '0;
    alu_d   = ALUResultIn;
    wreg_d  = WriteRegisterIn;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (fault) begin
            fault_d = 1'b1;
          end else begin
            Stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {ALUResultIn[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
          end
        end else begin
          regw_d = RegWriteIn;
          m2r_d  = MemToRegIn;
        end
      end
      BUSY: begin
        Stall = !bus.DMemAck;
        if (bus.DMemAck) begin
          req_d   = 1'b0;
          regw_d  = RegWriteIn;
          m2r_d   = MemToRegIn;
          rdout_d = is_load ? load_c : '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.DMemReq    = req_q;
  assign bus.DMemWe     = we_q;
  assign bus.DMemAddr   = addr_q;
  assign bus.DMemByteEn = be_q;
  assign bus.DMemWData  = wdata_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads with
// extraction, stores with wait states, faults, and reset mid-access.
module tb_mem_access_stage;
  logic        Clock = 1'b0;
  logic        ResetN;
  logic [31:0] ReadData2In, ALUResultIn, WriteRegisterIn;
  logic [1:0]  MemWriteIn, MemReadIn;
  logic        RegWriteIn, MemToRegIn;
  logic        Stall;
  logic [31:0] ReadDataOut, ALUResultOut, WriteRegisterOut;
  logic        RegWriteOut, MemToRegOut, AlignFault;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .Clock            (Clock),
    .ResetN           (ResetN),
    .ReadData2In      (ReadData2In),
    .ALUResultIn      (ALUResultIn),
    .WriteRegisterIn  (WriteRegisterIn),
    .MemWriteIn       (MemWriteIn),
    .MemReadIn        (MemReadIn),
    .RegWriteIn       (RegWriteIn),
    .MemToRegIn       (MemToRegIn),
    .bus              (bus),
    .Stall            (Stall),
    .ReadDataOut      (ReadDataOut),
    .ALUResultOut     (ALUResultOut),
    .WriteRegisterOut (WriteRegisterOut),
    .RegWriteOut      (RegWriteOut),
    .MemToRegOut      (MemToRegOut),
    .AlignFault       (AlignFault)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] rd2, input logic [31:0] wreg,
                        input logic regw, input logic m2r);
    MemReadIn       = rd;
    MemWriteIn      = wr;
    ALUResultIn     = addr;
    ReadData2In     = rd2;
    WriteRegisterIn = wreg;
    RegWriteIn      = regw;
    MemToRegIn      = m2r;
  endtask

  initial begin
    ResetN = 1'b0;
    set_op(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.DMemAck   = 1'b0;
    bus.DMemRData = 32'h0;
    tick();
    tick();
    chk("rst_rdata", ReadDataOut, 32'h0);
    chk("rst_alu", ALUResultOut, 32'h0);
    chk("rst_wreg", WriteRegisterOut, 32'h0);
    chk("rst_regw", 32'(RegWriteOut), 32'h0);
    chk("rst_m2r", 32'(MemToRegOut), 32'h0);
    chk("rst_req", 32'(bus.DMemReq), 32'h0);
    chk("rst_fault", 32'(AlignFault), 32'h0);
    ResetN = 1'b1;

    // ALU pass-through
    set_op(2'b00, 2'b00, 32'h1234, 32'h0, 32'd5, 1'b1, 1'b0);
    #1 chk("alu_stall", 32'(Stall), 32'h0);
    tick();
    chk("alu_out", ALUResultOut, 32'h1234);
    chk("alu_wreg", WriteRegisterOut, 32'd5);
    chk("alu_regw", 32'(RegWriteOut), 32'h1);
    chk("alu_req", 32'(bus.DMemReq), 32'h0);
    chk("alu_rdata", ReadDataOut, 32'h0);

    // lw 0x100, ack in first BUSY cycle
    set_op(2'b01, 2'b00, 32'h100, 32'h0, 32'd7, 1'b1, 1'b1);
    #1 chk("lw_stall_idle", 32'(Stall), 32'h1);
    tick();
    chk("lw_req", 32'(bus.DMemReq), 32'h1);
    chk("lw_we", 32'(bus.DMemWe), 32'h0);
    chk("lw_addr", bus.DMemAddr, 32'h100);
    chk("lw_be", 32'(bus.DMemByteEn), 32'hF);
    chk("lw_bubble", 32'(RegWriteOut), 32'h0);
    bus.DMemAck   = 1'b1;
    bus.DMemRData = 32'hDEADBEEF;
    #1 chk("lw_stall_ack", 32'(Stall), 32'h0);
    tick();
    bus.DMemAck = 1'b0;
    chk("lw_req_drop", 32'(bus.DMemReq), 32'h0);
    chk("lw_rdata", ReadDataOut, 32'hDEADBEEF);
    chk("lw_m2r", 32'(MemToRegOut), 32'h1);
    chk("lw_regw", 32'(RegWriteOut), 32'h1);
    chk("lw_wreg", WriteRegisterOut, 32'd7);

    // lb 0x103
    set_op(2'b11, 2'b00, 32'h103, 32'h0, 32'd8, 1'b1, 1'b1);
    tick();
    chk("lb_be", 32'(bus.DMemByteEn), 32'h8);
    chk("lb_addr", bus.DMemAddr, 32'h100);
    bus.DMemAck   = 1'b1;
    bus.DMemRData = 32'h80FFFFFF;
    tick();
    bus.DMemAck = 1'b0;
    chk("lb_rdata", ReadDataOut, 32'hFFFFFF80);

    // lh 0x102
    set_op(2'b10, 2'b00, 32'h102, 32'h0, 32'd9, 1'b1, 1'b1);
    tick();
    chk("lh_be", 32'(bus.DMemByteEn), 32'hC);
    bus.DMemAck   = 1'b1;
    bus.DMemRData = 32'h7FFF0000;
    tick();
    bus.DMemAck = 1'b0;
    chk("lh_rdata", ReadDataOut, 32'h00007FFF);

    // sh 0x106 with two wait cycles, ack in the third BUSY cycle
    set_op(2'b00, 2'b10, 32'h106, 32'hAAAA1234, 32'd0, 1'b0, 1'b0);
    #1 chk("sh_stall0", 32'(Stall), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(bus.DMemReq), 32'h1);
      chk("sh_we", 32'(bus.DMemWe), 32'h1);
      chk("sh_addr", bus.DMemAddr, 32'h104);
      chk("sh_be", 32'(bus.DMemByteEn), 32'hC);
      chk("sh_wdata", bus.DMemWData, 32'h12341234);
      bus.DMemAck = (i == 2);
      #1 chk("sh_stall", 32'(Stall), (i == 2) ? 32'h0 : 32'h1);
      tick();
    end
    bus.DMemAck = 1'b0;
    chk("sh_req_drop", 32'(bus.DMemReq), 32'h0);
    chk("sh_rdata", ReadDataOut, 32'h0);
    chk("sh_regw", 32'(RegWriteOut), 32'h0);

    // sb 0x101
    set_op(2'b00, 2'b11, 32'h101, 32'h00000034, 32'd0, 1'b0, 1'b0);
    tick();
    chk("sb_be", 32'(bus.DMemByteEn), 32'h2);
    chk("sb_wdata", bus.DMemWData, 32'h34343434);
    bus.DMemAck = 1'b1;
    tick();
    bus.DMemAck = 1'b0;

    // Misaligned lw 0x102
    set_op(2'b01, 2'b00, 32'h102, 32'h0, 32'd3, 1'b1, 1'b1);
    #1 chk("mis_stall", 32'(Stall), 32'h0);
    tick();
    chk("mis_req", 32'(bus.DMemReq), 32'h0);
    chk("mis_fault", 32'(AlignFault), 32'h1);
    chk("mis_regw", 32'(RegWriteOut), 32'h0);
    set_op(2'b00, 2'b00, 32'h55, 32'h0, 32'd4, 1'b1, 1'b0);
    tick();
    chk("mis_fault_pulse", 32'(AlignFault), 32'h0);
    chk("mis_next_alu", ALUResultOut, 32'h55);

    // Illegal op
    set_op(2'b01, 2'b01, 32'h100, 32'h0, 32'd3, 1'b1, 1'b0);
    #1 chk("ill_stall", 32'(Stall), 32'h0);
    tick();
    chk("ill_req", 32'(bus.DMemReq), 32'h0);
    chk("ill_fault", 32'(AlignFault), 32'h1);
    chk("ill_regw", 32'(RegWriteOut), 32'h0);
    set_op(2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("ill_fault_pulse", 32'(AlignFault), 32'h0);

    // Reset during BUSY
    set_op(2'b01, 2'b00, 32'h200, 32'h0, 32'd6, 1'b1, 1'b1);
    tick();
    chk("rb_req", 32'(bus.DMemReq), 32'h1);
    ResetN = 1'b0;
    set_op(2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("rb_req_drop", 32'(bus.DMemReq), 32'h0);
    chk("rb_addr", bus.DMemAddr, 32'h0);
    chk("rb_rdata", ReadDataOut, 32'h0);
    chk("rb_regw", 32'(RegWriteOut), 32'h0);
    ResetN = 1'b1;
    bus.DMemAck   = 1'b1;
    bus.DMemRData = 32'h12345678;
    #1 chk("rb_ack_stall", 32'(Stall), 32'h0);
    tick();
    bus.DMemAck = 1'b0;
    chk("rb_ack_req", 32'(bus.DMemReq), 32'h0);
    chk("rb_ack_rdata", ReadDataOut, 32'h0);
    chk("rb_ack_m2r", 32'(MemToRegOut), 32'h0);
    tick();
    chk("rb_idle_req", 32'(bus.DMemReq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
